// File: rtl/pc_fetch_ctrl.sv
// Program-counter fetch controller: issues one instruction-memory read, holds the
// fetched word until the core retires it, then advances to pc+4 or a jump target.
module pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_src,
   input  logic [31:0] jump_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ack,
   input  logic        stall,
   output logic        fault
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_instr;
   logic [31:0] w_instr_nxt;
   logic [31:0] r_instr_pc;
   logic [31:0] w_instr_pc_nxt;
   logic        r_fault;
   logic        w_fault_nxt;
   logic        w_retire;
   logic        w_jump_aligned;

   assign w_retire       = (r_state == S_HOLD) && instr_ack && !stall;
   assign w_jump_aligned = (jump_target[1:0] == 2'b00);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_instr    <= 32'h0;
         r_instr_pc <= 32'h0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pc       <= w_pc_nxt;
         r_instr    <= w_instr_nxt;
         r_instr_pc <= w_instr_pc_nxt;
         r_fault    <= w_fault_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_instr_nxt    = r_instr;
      w_instr_pc_nxt = r_instr_pc;
      w_fault_nxt    = r_fault;
      case (r_state)
         S_IDLE: w_state_nxt = S_FETCH;
         S_FETCH: begin
            if (imem_ready) begin
               w_instr_nxt    = imem_rdata;
               w_instr_pc_nxt = r_pc;
               w_state_nxt    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_retire) begin
               if (!pc_src) begin
                  w_pc_nxt    = r_pc + 32'd4;
                  w_state_nxt = S_FETCH;
               end else if (w_jump_aligned) begin
                  w_pc_nxt    = jump_target;
                  w_state_nxt = S_FETCH;
               end else begin
                  // misaligned target: pc is kept so it still points at the faulting instruction
                  w_fault_nxt = 1'b1;
                  w_state_nxt = S_FAULT;
               end
            end
         end
         S_FAULT: w_state_nxt = S_FAULT;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign imem_req    = (r_state == S_FETCH);
   assign imem_addr   = r_pc;
   assign instr_valid = (r_state == S_HOLD);
   assign instr       = r_instr;
   assign instr_pc    = r_instr_pc;
   assign fault       = r_fault;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed scenarios followed by random traffic, all checked each cycle against a
// flag-based reference model of the fetch/retire protocol.
module tb_pc_fetch_ctrl;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        pc_src;
   logic [31:0] jump_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ack;
   logic        stall;
   logic        fault;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: just-reset flag, holding-an-instruction flag, faulted flag
   logic        m_idle;
   logic        m_have;
   logic        m_fault;
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_ipc;

   pc_fetch_ctrl #(.RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .pc_src(pc_src), .jump_target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .instr_ack(instr_ack), .stall(stall), .fault(fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk("imem_req",    {31'h0, imem_req},    {31'h0, !m_idle && !m_have && !m_fault});
      chk("imem_addr",   imem_addr,            m_pc);
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_have && !m_fault});
      chk("instr",       instr,                m_instr);
      chk("instr_pc",    instr_pc,             m_ipc);
      chk("fault",       {31'h0, fault},       {31'h0, m_fault});
   endtask

   task automatic model_tick();
      if (rst) begin
         m_idle = 1'b1; m_have = 1'b0; m_fault = 1'b0;
         m_pc = RST_PC; m_instr = 32'h0; m_ipc = 32'h0;
      end else if (m_fault) begin
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else if (!m_have) begin
         if (imem_ready) begin
            m_instr = imem_rdata; m_ipc = m_pc; m_have = 1'b1;
         end
      end else if (instr_ack && !stall) begin
         m_have = 1'b0;
         if (!pc_src)                      m_pc = m_pc + 32'd4;
         else if (jump_target % 4 == 0)    m_pc = jump_target;
         else                              m_fault = 1'b1;
      end
   endtask

   // check outputs for the current cycle, then advance one clock
   task automatic cyc();
      check_model();
      @(posedge clk);
      model_tick();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; pc_src = 1'b0; jump_target = 32'h0; imem_ready = 1'b0;
      imem_rdata = 32'h0; instr_ack = 1'b0; stall = 1'b0;
      @(posedge clk);
      model_tick();
      @(negedge clk);

      // reset state and streaming at one instruction per two cycles
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      rst = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h0000_0013; instr_ack = 1'b1;
      cyc();
      chk("stream_addr0", imem_addr, 32'h0);
      cyc();
      chk("stream_valid", {31'h0, instr_valid}, 32'h1);
      cyc();
      chk("stream_addr4", imem_addr, 32'h4);
      cyc();
      cyc();
      chk("stream_addr8", imem_addr, 32'h8);
      chk("stream_req8", {31'h0, imem_req}, 32'h1);

      // memory wait states at address 8
      imem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("wait_addr", imem_addr, 32'h8);
         chk("wait_valid", {31'h0, instr_valid}, 32'h0);
      end
      imem_ready = 1'b1; imem_rdata = 32'hA5A5_0001; instr_ack = 1'b0;
      cyc();
      chk("wait_done_valid", {31'h0, instr_valid}, 32'h1);
      chk("wait_done_pc", instr_pc, 32'h8);

      // stall overrides ack
      instr_ack = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stall_pc", instr_pc, 32'h8);
         chk("stall_instr", instr, 32'hA5A5_0001);
         chk("stall_req", {31'h0, imem_req}, 32'h0);
      end
      stall = 1'b0;
      cyc();
      chk("stall_release_addr", imem_addr, 32'hC);

      // aligned jump, then misaligned jump faults
      cyc();
      pc_src = 1'b1; jump_target = 32'h0000_0100;
      cyc();
      chk("jump_addr", imem_addr, 32'h100);
      cyc();
      jump_target = 32'h0000_0102;
      cyc();
      chk("fault_set", {31'h0, fault}, 32'h1);
      for (int i = 0; i < 6; i++) begin
         imem_ready = 1'($urandom); instr_ack = 1'($urandom); pc_src = 1'($urandom);
         cyc();
         chk("fault_sticky", {31'h0, fault}, 32'h1);
         chk("fault_noreq", {31'h0, imem_req}, 32'h0);
      end

      // pc wrap at top of address space
      rst = 1'b1; cyc();
      rst = 1'b0; imem_ready = 1'b1; instr_ack = 1'b1; pc_src = 1'b1;
      jump_target = 32'hFFFF_FFFC;
      cyc(); cyc(); cyc();
      chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
      cyc();
      pc_src = 1'b0;
      cyc();
      chk("wrap_addr", imem_addr, 32'h0);
      chk("wrap_fault", {31'h0, fault}, 32'h0);

      // reset mid-fetch with memory ready in the same cycle
      cyc();
      pc_src = 1'b1; jump_target = 32'h0000_0040;
      cyc();
      chk("midfetch_addr", imem_addr, 32'h40);
      rst = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      cyc();
      chk("midfetch_instr", instr, 32'h0);
      chk("midfetch_req", {31'h0, imem_req}, 32'h0);
      rst = 1'b0;
      cyc();
      chk("midfetch_refetch", imem_addr, RST_PC);
      chk("midfetch_refetch_req", {31'h0, imem_req}, 32'h1);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst        = ($urandom_range(0, 99) == 0);
         imem_ready = ($urandom_range(0, 1) == 1);
         imem_rdata = $urandom;
         instr_ack  = ($urandom_range(0, 9) < 6);
         stall      = ($urandom_range(0, 3) == 0);
         pc_src     = ($urandom_range(0, 9) < 3);
         jump_target = $urandom;
         if ($urandom_range(0, 7) != 0) jump_target[1:0] = 2'b00;
         cyc();
      end
      check_model();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
